// File: rtl/score_input_conditioner.sv
// Score line conditioner: synchronises and debounces the raw Arduino score line,
// turns each confirmed rise into an event and queues events for a req/ack drain.
module score_input_conditioner #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int PEND_WIDTH      = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  score_in,
   input  logic                  game_active,
   input  logic                  score_ack,
   output logic                  score_req,
   output logic [PEND_WIDTH-1:0] pending,
   output logic                  overflow,
   output logic [15:0]           event_count
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0]      CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;

   typedef enum logic [1:0] {
      IDLE_LOW,
      CONFIRM_HIGH,
      IDLE_HIGH,
      CONFIRM_LOW
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [PEND_WIDTH-1:0]  pending_q, pending_d;
   logic                   overflow_q, overflow_d;
   logic [15:0]            event_count_q, event_count_d;

   logic synced;
   logic rise_evt;
   logic accept;
   logic ack_eff;

   assign sync_d = {sync_q[SYNC_STAGES-2:0], score_in};
   assign synced = sync_q[SYNC_STAGES-1];

   // Debounce: a new level must be seen on DEBOUNCE_CYCLES consecutive samples
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rise_evt = 1'b0;
      case (state_q)
         IDLE_LOW: begin
            if (synced) begin
               state_d = CONFIRM_HIGH;
               cnt_d   = CNT_W'(1);
            end
         end
         CONFIRM_HIGH: begin
            if (!synced) begin
               state_d = IDLE_LOW;
               cnt_d   = '0;
            end else if (cnt_q == CNT_MAX) begin
               state_d  = IDLE_HIGH;
               cnt_d    = '0;
               rise_evt = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         IDLE_HIGH: begin
            if (!synced) begin
               state_d = CONFIRM_LOW;
               cnt_d   = CNT_W'(1);
            end
         end
         CONFIRM_LOW: begin
            if (synced) begin
               state_d = IDLE_HIGH;
               cnt_d   = '0;
            end else if (cnt_q == CNT_MAX) begin
               state_d = IDLE_LOW;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE_LOW;
            cnt_d   = '0;
         end
      endcase
   end

   // An ack only counts when something is queued; an event and an ack cancel out
   always_comb begin
      accept        = rise_evt & game_active;
      ack_eff       = score_ack & (pending_q != '0);
      pending_d     = pending_q;
      overflow_d    = overflow_q;
      event_count_d = event_count_q + {15'd0, accept};
      if (!game_active) begin
         pending_d = '0;
      end else if (accept && !ack_eff) begin
         if (pending_q == PEND_MAX) begin
            overflow_d = 1'b1;
         end else begin
            pending_d = pending_q + PEND_WIDTH'(1);
         end
      end else if (!accept && ack_eff) begin
         pending_d = pending_q - PEND_WIDTH'(1);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_q        <= '0;
         state_q       <= IDLE_LOW;
         cnt_q         <= '0;
         pending_q     <= '0;
         overflow_q    <= 1'b0;
         event_count_q <= '0;
      end else begin
         sync_q        <= sync_d;
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         pending_q     <= pending_d;
         overflow_q    <= overflow_d;
         event_count_q <= event_count_d;
      end
   end

   assign score_req   = (pending_q != '0);
   assign pending     = pending_q;
   assign overflow    = overflow_q;
   assign event_count = event_count_q;

endmodule

// File: tb/tb_score_input_conditioner.sv
// Bench for score_input_conditioner: directed scenarios with literal expectations
// plus randomized stimulus, all checked each cycle against a run-length model.
module tb_score_input_conditioner;

   localparam int SS   = 2;
   localparam int DC   = 4;
   localparam int PW   = 4;
   localparam int PMAX = (1 << PW) - 1;

   logic          clock;
   logic          reset;
   logic          score_in;
   logic          game_active;
   logic          score_ack;
   logic          score_req;
   logic [PW-1:0] pending;
   logic          overflow;
   logic [15:0]   event_count;

   int n_cmp;
   int n_fail;

   // behavioural model state
   int        m_sync [SS];
   int        m_level;
   int        m_run;
   int        m_pend;
   bit        m_ovf;
   int        m_cnt;

   score_input_conditioner #(
      .SYNC_STAGES    (SS),
      .DEBOUNCE_CYCLES(DC),
      .PEND_WIDTH     (PW)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .score_in   (score_in),
      .game_active(game_active),
      .score_ack  (score_ack),
      .score_req  (score_req),
      .pending    (pending),
      .overflow   (overflow),
      .event_count(event_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < SS; i++) m_sync[i] = 0;
      m_level = 0;
      m_run   = 0;
      m_pend  = 0;
      m_ovf   = 1'b0;
      m_cnt   = 0;
   endtask

   // The debouncer is modelled as "how many consecutive samples disagree with the
   // confirmed level"; reaching DC flips the level, a rise yields an event.
   task automatic model_step();
      int  s;
      bit  ev;
      bit  ack;
      if (!reset) begin
         model_reset();
         return;
      end
      s  = m_sync[SS-1];
      for (int i = SS-1; i > 0; i--) m_sync[i] = m_sync[i-1];
      m_sync[0] = int'(score_in);
      ev = 1'b0;
      if (s == m_level) begin
         m_run = 0;
      end else begin
         m_run++;
         if (m_run == DC) begin
            m_level = s;
            m_run   = 0;
            ev      = (s == 1);
         end
      end
      if (!game_active) begin
         m_pend = 0;
      end else begin
         ack = score_ack && (m_pend > 0);
         if (ev) m_cnt = (m_cnt + 1) % 65536;
         if (ev && !ack) begin
            if (m_pend == PMAX) m_ovf = 1'b1;
            else m_pend++;
         end else if (!ev && ack) begin
            m_pend--;
         end
      end
   endtask

   task automatic compare_all();
      chk("score_req",   int'(score_req),   int'(m_pend != 0));
      chk("pending",     int'(pending),     m_pend);
      chk("overflow",    int'(overflow),    int'(m_ovf));
      chk("event_count", int'(event_count), m_cnt);
   endtask

   task automatic tick();
      @(posedge clock);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic pulse(input int h, input int l);
      score_in = 1'b1;
      repeat (h) tick();
      score_in = 1'b0;
      repeat (l) tick();
   endtask

   task automatic do_reset();
      reset = 1'b0;
      model_reset();
      tick();
      tick();
      reset = 1'b1;
   endtask

   initial begin
      int hold;
      int rst_hold;
      n_cmp       = 0;
      n_fail      = 0;
      reset       = 1'b1;
      score_in    = 1'b0;
      game_active = 1'b0;
      score_ack   = 1'b0;
      model_reset();
      #2 reset = 1'b0;
      #1;
      chk("rst_pending",   int'(pending),     0);
      chk("rst_req",       int'(score_req),   0);
      chk("rst_overflow",  int'(overflow),    0);
      chk("rst_count",     int'(event_count), 0);
      tick();
      tick();
      reset       = 1'b1;
      game_active = 1'b1;
      tick();

      // clean pulse: event lands on edge SS+DC = 6
      score_in = 1'b1;
      repeat (5) tick();
      chk("clean_pend_e5", int'(pending), 0);
      tick();
      chk("clean_pend_e6",  int'(pending),     1);
      chk("clean_req_e6",   int'(score_req),   1);
      chk("clean_count_e6", int'(event_count), 1);
      repeat (4) tick();
      score_in = 1'b0;
      repeat (8) tick();
      score_ack = 1'b1;
      tick();
      score_ack = 1'b0;
      chk("ack_pend", int'(pending),   0);
      chk("ack_req",  int'(score_req), 0);

      // glitch of 3 cycles
      pulse(3, 8);
      chk("glitch_count", int'(event_count), 1);
      chk("glitch_pend",  int'(pending),     0);

      // saturation
      do_reset();
      repeat (17) pulse(6, 6);
      chk("sat_pend",  int'(pending),     15);
      chk("sat_ovf",   int'(overflow),    1);
      chk("sat_count", int'(event_count), 17);
      score_ack = 1'b1;
      repeat (15) tick();
      score_ack = 1'b0;
      chk("drain_pend", int'(pending),  0);
      chk("drain_ovf",  int'(overflow), 1);

      // simultaneous event and ack
      repeat (3) pulse(6, 6);
      score_in = 1'b1;
      repeat (5) tick();
      score_ack = 1'b1;
      tick();
      score_ack = 1'b0;
      chk("simul_pend",  int'(pending),     3);
      chk("simul_count", int'(event_count), 21);
      score_in = 1'b0;
      repeat (6) tick();

      // inactive game flushes and drops events
      repeat (2) pulse(6, 6);
      chk("pre_flush_pend", int'(pending), 5);
      game_active = 1'b0;
      tick();
      chk("flush_pend", int'(pending), 0);
      pulse(6, 6);
      chk("inactive_count", int'(event_count), 23);
      chk("inactive_req",   int'(score_req),   0);
      game_active = 1'b1;

      // async reset mid-confirm with score_in held high
      do_reset();
      repeat (9) pulse(6, 6);
      score_ack = 1'b1;
      repeat (7) tick();
      score_ack = 1'b0;
      chk("pre_rst_pend",  int'(pending),     2);
      chk("pre_rst_count", int'(event_count), 9);
      score_in = 1'b1;
      repeat (4) tick();
      #2 reset = 1'b0;
      model_reset();
      #1;
      chk("mid_rst_pend",  int'(pending),     0);
      chk("mid_rst_req",   int'(score_req),   0);
      chk("mid_rst_count", int'(event_count), 0);
      tick();
      tick();
      reset = 1'b1;
      repeat (5) tick();
      chk("rel_count_e5", int'(event_count), 0);
      tick();
      chk("rel_count_e6", int'(event_count), 1);
      chk("rel_pend_e6",  int'(pending),     1);
      score_in = 1'b0;
      repeat (6) tick();

      // randomized phase
      hold     = 1;
      rst_hold = 0;
      for (int c = 0; c < 4000; c++) begin
         hold--;
         if (hold <= 0) begin
            score_in = ~score_in;
            hold     = int'($urandom_range(1, 9));
         end
         score_ack = ($urandom_range(0, 9) < 3);
         if ($urandom_range(0, 63) == 0) game_active = ~game_active;
         if (rst_hold > 0) begin
            rst_hold--;
            if (rst_hold == 0) reset = 1'b1;
         end else if ($urandom_range(0, 599) == 0) begin
            reset    = 1'b0;
            model_reset();
            rst_hold = int'($urandom_range(1, 2));
         end
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
